rs_encoder: RTL
===============

RS_ENCODER -- requirements
Module: rs_encoder

Interface
REQ-001 Parameter n, default 255, code frame length in symbols.
REQ-002 Parameter k, default 239, message symbols per frame.
REQ-003 Parameter t, default 8, correctable symbols; parity count is 2t = 16.
REQ-004 Parameter m, default 8, symbol width in bits.
REQ-005 clk_in  input  1  single clock; all state changes on its rising edge.
REQ-006 sys_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 in_valid  input  1  in_data carries a message symbol this cycle.
REQ-008 in_data  input  m  message symbol, first symbol = highest-degree coefficient.
REQ-009 in_ready  output  1  encoder accepts a symbol this cycle; a transfer occurs when in_valid and in_ready are both 1.
REQ-010 out_valid  output  1  out_data is a valid codeword symbol.
REQ-011 out_data  output  m  codeword symbol, registered.
REQ-012 out_sof  output  1  high with the first codeword symbol of a frame.
REQ-013 out_eof  output  1  high with the last (255th) codeword symbol of a frame.
REQ-014 out_parity  output  1  high while out_data is a parity symbol.

Function
REQ-015 Field GF(2^8), primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D), alpha = 0x02.
REQ-016 Generator g(x) = product over i=1..16 of (x + alpha^i), monic, degree 16; coefficients g0..g15 are hard-wired constants.
REQ-017 Encoding systematic: codeword = 239 message symbols unchanged, then 16 parity symbols = x^16*M(x) mod g(x), highest degree first.
REQ-018 Parity computed by a 16-stage, m-bit LFSR with constant GF multipliers: feedback fb = in_data XOR p15; p_j <= p_(j-1) XOR g_j*fb, p_0 <= g_0*fb.
REQ-019 States: IDLE, MSG, PAR; 8-bit symbol counter cnt.
REQ-020 IDLE: in_ready=1; accepted symbol -> MSG, cnt=1, LFSR updated from all-zero state, out_sof asserted with that symbol.
REQ-021 MSG: in_ready=1; each accepted symbol increments cnt and updates LFSR; the 239th accepted symbol -> PAR, cnt=0.
REQ-022 in_valid low in IDLE/MSG: no transfer, LFSR and cnt hold, out_valid=0 next cycle; gaps of any length allowed.
REQ-023 PAR: in_ready=0; emits p15..p0 on 16 consecutive cycles, shifting LFSR with zero feedback; out_parity=1 throughout.
REQ-024 16th parity symbol carries out_eof=1; next state IDLE, LFSR zeroed, in_ready=1 the following cycle (one dead cycle between back-to-back frames at most).
REQ-025 Latency: message symbol accepted in cycle c appears on out_data with out_valid=1 in cycle c+1; first parity appears cycle after the 239th symbol's output.
REQ-026 in_valid asserted during PAR ignored; no symbol consumed, no state disturbed.
REQ-027 Output has no backpressure; downstream always accepts.
REQ-028 out_sof and out_eof never high in the same cycle; each pulses once per frame.

Reset
REQ-029 sys_rst_n low: immediately state=IDLE, cnt=0, LFSR=0, out_valid=0, out_data=0, out_sof=0, out_eof=0, out_parity=0; in_ready=1 after release.
REQ-030 Reset mid-frame discards the partial frame; first symbol after release starts a new frame with out_sof.

Verification
REQ-031 239 symbols of 0x00, in_valid continuous -> 239 outputs 0x00 then 16 parity 0x00, out_eof on output 255, out_sof on output 1.
REQ-032 238 zeros then 0x01 -> 16 parity symbols equal g15..g0 in order; reference-model compare.
REQ-033 Random message with random in_valid gaps -> identical codeword to gap-free run; out_valid count exactly 255.
REQ-034 Two frames back-to-back, in_valid held high -> in_ready low exactly 16 cycles per frame, second frame parity independent of first (matches model).
REQ-035 sys_rst_n pulsed low at message symbol 100 -> all outputs 0 during reset; following full frame matches model.
REQ-036 Round trip: encoder output with up to 8 injected symbol errors into team decoder -> errors corrected; 9 errors -> decoder flags uncorrectable.

Source files
------------

// File: rtl/rs_encoder_if.sv
// Symbol stream bundle for the RS encoder: message input with ready/valid,
// codeword output with frame markers.
interface rs_encoder_if #(
    parameter int m = 8
);
    logic         in_valid;
    logic [m-1:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [m-1:0] out_data;
    logic         out_sof;
    logic         out_eof;
    logic         out_parity;

    modport master (
        output in_valid, in_data,
        input  in_ready, out_valid, out_data, out_sof, out_eof, out_parity
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, out_valid, out_data, out_sof, out_eof, out_parity
    );
endinterface

// File: rtl/rs_encoder.sv
// Systematic RS(255,239) encoder over GF(2^8): message symbols pass through,
// followed by 2t parity symbols drained from a constant-multiplier LFSR.
//
// state | meaning
// IDLE  | waiting for the first message symbol of a frame, LFSR is zero
// MSG   | accepting message symbols, cnt = symbols accepted so far
// PAR   | input stalled, shifting out parity, cnt = parity symbols sent
module rs_encoder #(
    parameter int n = 255,
    parameter int k = 239,
    parameter int t = 8,
    parameter int m = 8
) (
    input  logic          clk_in,
    input  logic          sys_rst_n,
    rs_encoder_if.slave   bus
);
    localparam int NP = 2 * t;
    localparam logic [m:0]   PRIM   = (m+1)'(9'h11D);
    localparam logic [7:0]   K_LAST = 8'(k - 1);
    localparam logic [7:0]   P_LAST = 8'(n - k - 1);

    function automatic logic [m-1:0] gf_mul(input logic [m-1:0] a, input logic [m-1:0] b);
        logic [m-1:0] acc;
        logic [m-1:0] sh;
        acc = '0;
        sh  = a;
        for (int i = 0; i < m; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[m-2:0], 1'b0} ^ (sh[m-1] ? PRIM[m-1:0] : '0);
        end
        return acc;
    endfunction

    // g(x) = prod_{i=1..2t} (x + alpha^i); the monic top term is implicit.
    function automatic logic [NP-1:0][m-1:0] gen_poly();
        logic [NP:0][m-1:0] g;
        logic [m-1:0]       root;
        g    = '0;
        g[0] = m'(1);
        root = m'(1);
        for (int i = 1; i <= NP; i++) begin
            root = gf_mul(root, m'(2));
            for (int j = NP; j > 0; j--) g[j] = g[j-1] ^ gf_mul(g[j], root);
            g[0] = gf_mul(g[0], root);
        end
        return g[NP-1:0];
    endfunction

    localparam logic [NP-1:0][m-1:0] G = gen_poly();

    typedef enum logic [1:0] {IDLE, MSG, PAR} state_t;

    state_t                 state;
    logic [7:0]             cnt;
    logic [NP-1:0][m-1:0]   p;
    logic [m-1:0]           fb;

    assign fb           = bus.in_data ^ p[NP-1];
    assign bus.in_ready = (state != PAR);

    always_ff @(posedge clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            p              <= '0;
            bus.out_valid  <= 1'b0;
            bus.out_data   <= '0;
            bus.out_sof    <= 1'b0;
            bus.out_eof    <= 1'b0;
            bus.out_parity <= 1'b0;
        end else begin
            bus.out_valid  <= 1'b0;
            bus.out_sof    <= 1'b0;
            bus.out_eof    <= 1'b0;
            bus.out_parity <= 1'b0;
            case (state)
                IDLE, MSG: begin
                    if (bus.in_valid) begin
                        bus.out_valid <= 1'b1;
                        bus.out_data  <= bus.in_data;
                        bus.out_sof   <= (state == IDLE);
                        p[0] <= gf_mul(G[0], fb);
                        for (int j = 1; j < NP; j++) p[j] <= p[j-1] ^ gf_mul(G[j], fb);
                        if (cnt == K_LAST) begin
                            state <= PAR;
                            cnt   <= '0;
                        end else begin
                            state <= MSG;
                            cnt   <= cnt + 8'd1;
                        end
                    end
                end
                PAR: begin
                    bus.out_valid  <= 1'b1;
                    bus.out_data   <= p[NP-1];
                    bus.out_parity <= 1'b1;
                    p[0] <= '0;
                    for (int j = 1; j < NP; j++) p[j] <= p[j-1];
                    if (cnt == P_LAST) begin
                        bus.out_eof <= 1'b1;
                        state       <= IDLE;
                        cnt         <= '0;
                        p           <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
